arb_req_shaper: RTL and testbench

- Upstream front-end for the 3-requester round-return grant FSM (r[2:0] in, one-hot g[2:0] out).
- Converts per-requester single-cycle job pulses, each carrying a beat count, into a level request `r[i]`.
- Holds `r[i]` high for exactly `len` granted cycles, then drops it for one cycle so the arbiter returns to its idle state.
- Also reports starvation and protocol errors.

---
 rtl/arb_req_shaper.sv | 142 ++++++++++++++
 tb/tb_arb_req_shaper.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_shaper.sv
// arb_req_shaper
//   Front-end for a 3-requester round-return grant arbiter. Each channel turns
//   a single-cycle job pulse carrying a beat count into a level request r[i].
//   The request is held until the job's beats have been granted, then dropped
//   for one release cycle so the arbiter can fall back to its idle state.
//   Starvation and protocol errors are reported as sticky flags.
//
// Ports
//   clk      in   clock, rising edge
//   resetn   in   asynchronous active-low reset
//   start    in   [N]        per-channel job pulse
//   len      in   [N*LEN_W]  per-channel beat count (0 means 1 beat)
//   g        in   [N]        one-hot grant from the arbiter
//   clr_err  in   synchronous clear of the sticky flags (a same-cycle set wins)
//   r        out  [N]        registered request level
//   ready    out  [N]        channel idle, can accept start
//   beat     out  [N]        transfer beat this cycle
//   done     out  [N]        1-cycle pulse the cycle after the last beat
//   starve   out  [N]        sticky: MAX_WAIT consecutive ungranted cycles
//   err_ovf  out  [N]        sticky: start seen while not ready (job dropped)
//   err_gnt  out  [N]        sticky: grant seen while idle
module arb_req_shaper #(
  parameter int N        = 3,
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N-1:0]       start,
  input  logic [N*LEN_W-1:0] len,
  input  logic [N-1:0]       g,
  input  logic               clr_err,
  output logic [N-1:0]       r,
  output logic [N-1:0]       ready,
  output logic [N-1:0]       beat,
  output logic [N-1:0]       done,
  output logic [N-1:0]       starve,
  output logic [N-1:0]       err_ovf,
  output logic [N-1:0]       err_gnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, REL} st_t;

  st_t               st_q   [N];
  st_t               st_d   [N];
  logic [LEN_W-1:0]  cnt_q  [N];
  logic [LEN_W-1:0]  cnt_d  [N];
  logic [WAIT_W-1:0] wait_q [N];
  logic [WAIT_W-1:0] wait_d [N];
  logic [N-1:0]      done_d;
  logic [N-1:0]      starve_d;
  logic [N-1:0]      ovf_d;
  logic [N-1:0]      gnt_d;

  // Ungranted-cycle counter stops at MAX_WAIT so it never wraps.
  function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] w);
    if (w >= WAIT_W'(MAX_WAIT)) return WAIT_W'(MAX_WAIT);
    return w + 1'b1;
  endfunction

  // A zero length is promoted to one beat so the countdown never passes zero.
  function automatic logic [LEN_W-1:0] job_beats(input logic [LEN_W-1:0] l);
    if (l == '0) return LEN_W'(1);
    return l;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_out
    assign r[gi]     = (st_q[gi] == REQ);
    assign ready[gi] = (st_q[gi] == IDLE);
    assign beat[gi]  = (st_q[gi] == REQ) & g[gi];
  end

  always_comb begin
    done_d   = '0;
    starve_d = starve & ~{N{clr_err}};
    ovf_d    = err_ovf & ~{N{clr_err}};
    gnt_d    = err_gnt & ~{N{clr_err}};
    for (int i = 0; i < N; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      wait_d[i] = wait_q[i];
      case (st_q[i])
        IDLE: begin
          if (start[i]) begin
            st_d[i]   = REQ;
            cnt_d[i]  = job_beats(len[i*LEN_W +: LEN_W]);
            wait_d[i] = '0;
          end
          if (g[i]) gnt_d[i] = 1'b1;
        end
        REQ: begin
          if (start[i]) ovf_d[i] = 1'b1;
          if (g[i]) begin
            wait_d[i] = '0;
            if (cnt_q[i] == LEN_W'(1)) begin
              st_d[i]   = REL;
              done_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - 1'b1;
            end
          end else begin
            wait_d[i] = wait_inc(wait_q[i]);
            if (wait_q[i] == WAIT_W'(MAX_WAIT - 1)) starve_d[i] = 1'b1;
          end
        end
        REL: begin
          // The arbiter still shows our grant here; it is neither a beat nor an error.
          if (start[i]) ovf_d[i] = 1'b1;
          st_d[i] = IDLE;
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin
        st_q[i]   <= IDLE;
        cnt_q[i]  <= '0;
        wait_q[i] <= '0;
      end
      done    <= '0;
      starve  <= '0;
      err_ovf <= '0;
      err_gnt <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        st_q[i]   <= st_d[i];
        cnt_q[i]  <= cnt_d[i];
        wait_q[i] <= wait_d[i];
      end
      done    <= done_d;
      starve  <= starve_d;
      err_ovf <= ovf_d;
      err_gnt <= gnt_d;
    end
  end

endmodule

// File: tb/tb_arb_req_shaper.sv
// Bench for arb_req_shaper: two instances (MAX_WAIT 16 and 8) share stimulus,
// each driven by its own round-return arbiter model.
module tb_arb_req_shaper;

  logic        clk = 1'b0;
  logic        resetn;
  logic        clr_err;
  logic [2:0]  start;
  logic [2:0]  g_force;
  logic [11:0] len;

  logic [2:0] r_a, ready_a, beat_a, done_a, starve_a, ovf_a, gnt_a, g_a;
  logic [2:0] r_b, ready_b, beat_b, done_b, starve_b, ovf_b, gnt_b, g_b;
  logic [1:0] arb_a, arb_b;

  int n_chk = 0;
  int n_err = 0;
  int cyc;
  int n_r[3], n_beat[3], n_done[3], n_rel[3], done_at[3], first_beat[3], st_first[3];

  always #5 clk = ~clk;

  arb_req_shaper #(.N(3), .LEN_W(4), .MAX_WAIT(16)) dut_a (
    .clk(clk), .resetn(resetn), .start(start), .len(len), .g(g_a), .clr_err(clr_err),
    .r(r_a), .ready(ready_a), .beat(beat_a), .done(done_a), .starve(starve_a),
    .err_ovf(ovf_a), .err_gnt(gnt_a));

  arb_req_shaper #(.N(3), .LEN_W(4), .MAX_WAIT(8)) dut_b (
    .clk(clk), .resetn(resetn), .start(start), .len(len), .g(g_b), .clr_err(clr_err),
    .r(r_b), .ready(ready_b), .beat(beat_b), .done(done_b), .starve(starve_b),
    .err_ovf(ovf_b), .err_gnt(gnt_b));

  // Arbiter model: state 0 idle, k = granting channel k-1; a granted owner
  // keeps the grant until its request drops, then the arbiter goes idle.
  function automatic logic [2:0] onehot(input logic [1:0] s);
    case (s)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] arb_next(input logic [1:0] s, input logic [2:0] rq);
    if (s == 2'd0) begin
      if (rq[0]) return 2'd1;
      if (rq[1]) return 2'd2;
      if (rq[2]) return 2'd3;
      return 2'd0;
    end
    if ((rq & onehot(s)) == 3'b000) return 2'd0;
    return s;
  endfunction

  assign g_a = onehot(arb_a) | g_force;
  assign g_b = onehot(arb_b) | g_force;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arb_a <= 2'd0;
      arb_b <= 2'd0;
    end else begin
      arb_a <= arb_next(arb_a, r_a);
      arb_b <= arb_next(arb_b, r_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_len(input int ch, input int v);
    len[ch*4 +: 4] = 4'(v);
  endtask

  task automatic clr_mon();
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      n_r[i] = 0; n_beat[i] = 0; n_done[i] = 0; n_rel[i] = 0;
      done_at[i] = -1; first_beat[i] = -1; st_first[i] = -1;
    end
  endtask

  // Advance one clock and record what instance a (and b's starve) shows.
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (r_a[i]) n_r[i]++;
      if (beat_a[i]) begin
        n_beat[i]++;
        if (first_beat[i] < 0) first_beat[i] = cyc;
      end
      if (done_a[i]) begin
        n_done[i]++;
        done_at[i] = cyc;
      end
      if (!r_a[i] && !ready_a[i]) n_rel[i]++;
      if (starve_b[i] && st_first[i] < 0) st_first[i] = cyc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = '0; len = '0; clr_err = 1'b0; g_force = '0;
    clr_mon();
    #2;
    chk("rst_r", r_a, 0);
    chk("rst_ready", ready_a, 3'b111);
    chk("rst_flags", {done_a, starve_a, ovf_a, gnt_a}, 0);
    chk("rst_b", {beat_b, done_b, starve_b, ovf_b, gnt_b, r_b, ready_b}, 21'b111);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    // Single job ch0 len=3
    clr_mon(); set_len(0, 3); start = 3'b001;
    tick(); start = '0;
    repeat (7) tick();
    chk("single_r", n_r[0], 4);
    chk("single_beat", n_beat[0], 3);
    chk("single_first", first_beat[0], 2);
    chk("single_done", n_done[0], 1);
    chk("single_done_at", done_at[0], 5);
    chk("single_rel", n_rel[0], 1);
    chk("single_ready", ready_a, 3'b111);
    chk("single_noerr", {ovf_a, gnt_a}, 0);

    // len=0 on ch2
    clr_mon(); set_len(2, 0); start = 3'b100;
    tick(); start = '0;
    repeat (5) tick();
    chk("len0_beat", n_beat[2], 1);
    chk("len0_r", n_r[2], 2);
    chk("len0_done_at", done_at[2], 3);
    chk("len0_done", n_done[2], 1);

    // Contention ch1 len=5, ch2 len=2
    clr_mon(); set_len(1, 5); set_len(2, 2); start = 3'b110;
    tick(); start = '0;
    repeat (13) tick();
    chk("cont_beat1", n_beat[1], 5);
    chk("cont_beat2", n_beat[2], 2);
    chk("cont_done1", done_at[1], 7);
    chk("cont_first2", first_beat[2], 9);
    chk("cont_done2", done_at[2], 11);
    chk("cont_starve", starve_a, 0);

    // Overflow: restart ch0 while in REQ
    clr_mon(); set_len(0, 4); start = 3'b001;
    tick(); set_len(0, 9);
    tick(); start = '0;
    repeat (8) tick();
    chk("ovf_beat", n_beat[0], 4);
    chk("ovf_done", n_done[0], 1);
    chk("ovf_flag", ovf_a, 3'b001);

    // Grant while idle, then set-vs-clear priority, then clear
    g_force = 3'b010; tick(); g_force = '0;
    chk("gnt_flag", gnt_a, 3'b010);
    g_force = 3'b010; clr_err = 1'b1; tick();
    chk("gnt_set_wins", gnt_a, 3'b010);
    chk("ovf_cleared", ovf_a, 0);
    g_force = '0; tick(); clr_err = 1'b0;
    chk("gnt_cleared", gnt_a, 0);
    chk("b_flags_cleared", starve_b, 0);

    // Starvation: ch0 len=15, ch1 started while ch0 granted
    clr_mon(); set_len(0, 15); start = 3'b001;
    tick(); start = '0;
    tick(); tick();
    set_len(1, 1); start = 3'b010;
    tick(); start = '0;
    repeat (21) tick();
    chk("stv_first_b", st_first[1], 12);
    chk("stv_sticky_b", starve_b, 3'b010);
    chk("stv_a_clear", starve_a, 0);
    chk("stv_beat0", n_beat[0], 15);
    chk("stv_beat1", n_beat[1], 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("stv_cleared", starve_b, 0);

    // Async reset during beat 2 of 4
    clr_mon(); set_len(0, 4); start = 3'b001;
    tick();
    tick(); start = '0;
    tick();
    chk("rstj_ovf", ovf_a, 3'b001);
    chk("rstj_beat", beat_a, 3'b001);
    resetn = 1'b0;
    #1;
    chk("rstj_r", r_a, 0);
    chk("rstj_ready", ready_a, 3'b111);
    chk("rstj_flags", {done_a, ovf_a, beat_a}, 0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("rstj_nodone", n_done[0], 0);
    clr_mon(); set_len(0, 2); start = 3'b001;
    tick(); start = '0;
    repeat (6) tick();
    chk("post_beat", n_beat[0], 2);
    chk("post_done", n_done[0], 1);
    chk("post_done_at", done_at[0], 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
